serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder built around a single one-bit full-adder cell, itself formed from two half-adder stages plus an OR. It sits directly downstream of the combinational half/full-adder datapath. It accepts two operands and a carry-in over a valid/ready handshake, then adds them LSB-first, one bit per clock, through a registered carry. It returns the sum, carry-out and signed overflow on a second valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width. Legal range is 1 to 32.

Ports:
- `clk`, input, 1: single rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the operands are valid.
- `in_ready`, output, 1: the block can accept operands.
- `a`, input, WIDTH: operand A (unsigned or two's complement).
- `b`, input, WIDTH: operand B.
- `cin`, input, 1: carry-in.
- `out_valid`, output, 1: the result is valid.
- `out_ready`, input, 1: the consumer accepts the result.
- `sum`, output, WIDTH: the computed sum, `a + b + cin` mod 2^WIDTH.
- `cout`, output, 1: carry out of the MSB.
- `ovf`, output, 1: signed overflow, equal to the carry into the MSB XOR `cout`.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **IDLE:**
  - `in_ready`=1 and `out_valid`=0.
  - When `in_valid`=1, the block loads `a_sr`←`a`, `b_sr`←`b`, `carry`←`cin`, `cnt`←0, and moves to SHIFT.
- **SHIFT:** each cycle the block does the following.
  - The cell computes `s = a_sr[0]^b_sr[0]^carry` and `c = maj(a_sr[0], b_sr[0], carry)`.
  - `sum_sr` shifts right, with `s` entering at bit WIDTH-1.
  - `a_sr` and `b_sr` shift right.
  - `carry`←`c`.
  - `cnt` increments.
  - On the cycle where `cnt`==WIDTH-1, the block also latches `ovf`←(carry into this bit)^`c` and moves to DONE.
- **DONE:**
  - `out_valid`=1; `sum`, `cout` and `ovf` are stable.
  - When `out_ready`=1, the block moves to IDLE.
- `in_ready` is 1 only in IDLE. Inputs presented in SHIFT or DONE are ignored and not queued.
- `sum`, `cout` and `ovf` are driven from registers only, so no combinational path exists from any input to any output.
- WIDTH=1 is legal: SHIFT lasts exactly one cycle.
- `cnt` width is max(1, $clog2(WIDTH)) bits. There is no wrap-around beyond WIDTH-1.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0. All internal shift registers, `carry` and `cnt` reset to 0.
- **Reset mid-operation:** asserting `rst_n`=0 in SHIFT or DONE aborts the operation immediately (asynchronously). The result is discarded and no `out_valid` pulse follows the release of reset.
- **Latency:** the input handshake completes on edge k, and `out_valid` rises after edge k+WIDTH.
- **Minimum initiation interval:** WIDTH+2 cycles, made up of WIDTH cycles of SHIFT, at least one cycle of DONE, and one cycle of IDLE.
- **Back-pressure:** while `out_ready`=0 the block holds DONE indefinitely, with the outputs unchanged.
- **Output handshake:** completes on the edge where `out_valid`&`out_ready`=1. `out_valid` falls on that same edge.
- **Simultaneous events:** `in_valid` asserted in the same cycle the block returns to IDLE is accepted on the following edge, not earlier.

## Structure
- Shared package `serial_adder_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t`;
  - the `MAX_WIDTH` = 32 constant.
- Sub-module `full_adder_cell` (inputs a, b, ci; outputs s, co) is built from two half-adder stages. It is purely combinational and is instantiated once.
- The top level contains the FSM, the shift registers, `cnt`, the `carry` register and the output registers.

## Test plan
All scenarios use WIDTH=8 unless stated otherwise.
- `a`=0x00, `b`=0x00, `cin`=0 → `sum`=0x00, `cout`=0, `ovf`=0. `out_valid` rises exactly 8 cycles after the input handshake.
- `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1, `ovf`=0. `a`=0x7F, `b`=0x01 → `sum`=0x80, `cout`=0, `ovf`=1. `a`=0x80, `b`=0x80 → `sum`=0x00, `cout`=1, `ovf`=1.
- `a`=0x5A, `b`=0x33, `cin`=1, with `out_ready` held at 0 for 5 cycles → `sum`=0x8E and `cout`=0 are held stable while `out_valid`=1. In those cycles `in_ready`=0, and an `in_valid` pulse is ignored.
- Reset mid-operation: `rst_n` pulsed low on cycle 3 of SHIFT → all outputs return to their reset values at once. No `out_valid` follows; the next operation 0x10+0x20 returns 0x30.
- WIDTH=1, exhaustive {`a`, `b`, `cin`} over 000 to 111 → `sum`/`cout` match the full-adder truth table, with latency 1.
- 1000 random back-to-back operations with random `out_ready` stalls, checked against the reference model `{cout, sum} = a + b + cin` and `ovf` computed from the operand signs.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR on the carries.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;
    logic g0;
    logic g1;

    always_comb begin
        p  = a ^ b;
        g0 = a & b;
        s  = p ^ ci;
        g1 = p & ci;
        co = g0 | g1;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, a registered carry, LSB first.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output sa_state_t        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on state and out_valid is never withdrawn
    // before its transfer completes; neither depends combinationally on inputs.

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;
    logic last_bit;

    full_adder_cell u_cell (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_sr_d              = a_sr_q >> 1;
                b_sr_d              = b_sr_q >> 1;
                sum_sr_d            = sum_sr_q >> 1;
                sum_sr_d[WIDTH-1]   = fa_s;
                carry_d             = fa_co;
                // On the MSB, carry_q is the carry into the sign bit.
                if (last_bit) begin
                    sum_d  = sum_sr_d;
                    cout_d = fa_co;
                    ovf_d  = carry_q ^ fa_co;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corners, WIDTH=1 truth table, random traffic.
module tb_serial_adder;
    import serial_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic       in_valid, in_ready, cin8, out_valid, out_ready, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    sa_state_t  st8;

    logic      iv1, ir1, ov1, or1, co1, of1;
    logic [0:0] a1, b1, c1_vec, s1;
    sa_state_t st1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         lat;
        bit         timeout;
        logic       ready_after;
        logic       valid_after;
    } obs_t;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .dbg_state(st8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .cin(c1_vec[0]),
        .out_valid(ov1), .out_ready(or1),
        .sum(s1), .cout(co1), .ovf(of1), .dbg_state(st1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Returns {ovf, cout, sum[7:0]} from plain integer arithmetic and operand signs.
    function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned total;
        logic [7:0]  s;
        logic        co, ov;
        total = int'(x) + int'(y) + int'(c);
        s     = total[7:0];
        co    = (total > 255);
        ov    = (x[7] == y[7]) && (s[7] != x[7]);
        return {ov, co, s};
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input int stall, output obs_t o);
        int n;
        o = '{sum: 8'h00, cout: 1'b0, ovf: 1'b0, lat: 0, timeout: 1'b0,
              ready_after: 1'b0, valid_after: 1'b0};
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            o.timeout = 1'b1;
            return;
        end
        a8 = ia; b8 = ib; cin8 = ic; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && o.lat < 100) begin
            @(negedge clk);
            o.lat++;
        end
        if (o.lat >= 100) begin
            o.timeout = 1'b1;
            return;
        end
        o.sum  = sum8;
        o.cout = cout8;
        o.ovf  = ovf8;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        o.ready_after = in_ready;
        o.valid_after = out_valid;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, sum8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_w8: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want rdy=1 vld=0 sum=00 cout=0 ovf=0",
                     in_ready, out_valid, sum8, cout8, ovf8);
        end
        checks++;
        if ({ir1, ov1, s1, co1, of1} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_w1: got %b want 10000", {ir1, ov1, s1, co1, of1});
        end
    endtask

    task automatic test_basic();
        logic [7:0] ta [4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] tb [4] = '{8'h00, 8'h01, 8'h01, 8'h80};
        logic [9:0] want [4] = '{{1'b0, 1'b0, 8'h00}, {1'b0, 1'b1, 8'h00},
                                 {1'b1, 1'b0, 8'h80}, {1'b1, 1'b1, 8'h00}};
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 1'b0, 0, o);
            checks++;
            if (o.timeout || {o.ovf, o.cout, o.sum} !== want[i]) begin
                errors++;
                $display("FAIL basic_%0d: got ovf/cout/sum=%b/%b/%h timeout=%0b, want %b/%b/%h",
                         i, o.ovf, o.cout, o.sum, o.timeout, want[i][9], want[i][8], want[i][7:0]);
            end
            checks++;
            if (o.lat != 8) begin
                errors++;
                $display("FAIL latency_%0d: got %0d cycles, want 8", i, o.lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL bp_wait: out_valid never rose");
        end
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, sum8, cout8, ovf8} !== {1'b1, 1'b0, 8'h8E, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b, want 1 0 8e 0 1",
                         i, out_valid, in_ready, sum8, cout8, ovf8);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_not_queued: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        int   n;
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        // New request presented in the same cycle the result is taken.
        a8 = 8'h40; b8 = 8'h41; cin8 = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL simul_idle: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL simul_accept: got rdy=%b, want 0", in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 8 || sum8 !== 8'h82 || cout8 !== 1'b0 || ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL simul_result: got lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=82 cout=0 ovf=1",
                     n, sum8, cout8, ovf8);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        o.lat = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   n;
        bit   seen;
        run_op(8'hC0, 8'hC1, 1'b1, 0, o);
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sum8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 00 0 0",
                     in_ready, out_valid, sum8, cout8, ovf8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_no_valid: got out_valid pulse after reset, want none");
        end
        run_op(8'h10, 8'h20, 1'b0, 0, o);
        checks++;
        if (o.timeout || o.sum !== 8'h30 || o.cout !== 1'b0 || o.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_op: got sum=%h cout=%b ovf=%b, want sum=30 cout=0 ovf=0",
                     o.sum, o.cout, o.ovf);
        end
    endtask

    task automatic test_width1();
        int n;
        int lat;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            n = 0;
            while (ir1 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            a1 = v[2]; b1 = v[1]; c1_vec = v[0]; iv1 = 1'b1;
            @(negedge clk);
            iv1 = 1'b0;
            lat = 0;
            while (ov1 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
            checks++;
            if (lat != 1 || s1[0] !== (v[2] ^ v[1] ^ v[0]) ||
                co1 !== ((v[2] + v[1] + v[0]) >= 2)) begin
                errors++;
                $display("FAIL width1_%b: got lat=%0d s=%b co=%b, want lat=1 s=%b co=%b",
                         v, lat, s1[0], co1, v[2] ^ v[1] ^ v[0], (v[2] + v[1] + v[0]) >= 2);
            end
            or1 = 1'b1;
            @(negedge clk);
            or1 = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        obs_t       o;
        logic [7:0] exp_q [$];
        logic [7:0] x, y;
        logic       c;
        logic [9:0] r;
        int         bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            c = 1'($urandom);
            r = ref_add(x, y, c);
            exp_q.push_back(r[7:0]);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            run_op(x, y, c, $urandom_range(0, 3), o);
            checks++;
            if (o.timeout || o.sum !== exp_q.pop_front() || o.cout !== r[8] || o.ovf !== r[9] ||
                o.lat != 8 || o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d: %h+%h+%b got sum=%h cout=%b ovf=%b lat=%0d rdy=%b vld=%b, want sum=%h cout=%b ovf=%b lat=8 rdy=1 vld=0",
                             i, x, y, c, o.sum, o.cout, o.ovf, o.lat, o.ready_after, o.valid_after,
                             r[7:0], r[8], r[9]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; c1_vec = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_width1();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
